ml_kem_encaps_stream: RTL and testbench

- Parametrised, byte-streaming successor to the fixed Kyber-768 encapsulation top.
- Selects the parameter set per operation: k = 2, 3 or 4 (ML-KEM-512/768/1024).
- Accepts ek and m over a valid/ready byte stream and applies the FIPS 203 ek modulus check while bytes arrive.
- Drives an external encaps core over a start/done handshake, then streams the ciphertext out and presents the shared key K.

---
 rtl/ml_kem_encaps_stream.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_ml_kem_encaps_stream.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ml_kem_encaps_stream.sv
`default_nettype none
// ============================================================================
// Module      : ml_kem_encaps_stream
// Description : Byte-streaming ML-KEM encapsulation wrapper. Loads ek and m
//               for rank k = 2/3/4 while checking the ek coefficient modulus,
//               drives an external encaps core, then streams the ciphertext.
// Revision    : 1.0 - initial release
// ============================================================================
module ml_kem_encaps_stream #(
   parameter int K_MAX        = 4,
   parameter int EK_BYTES_MAX = 1568,
   parameter int CT_BYTES_MAX = 1568,
   parameter int MSG_BYTES    = 32,
   parameter int KEY_WIDTH    = 256
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [1:0]                mode,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [7:0]                in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [7:0]                out_data,
   output logic                      out_last,
   output logic [KEY_WIDTH-1:0]      K,
   output logic                      done,
   output logic                      error,
   output logic                      busy,
   output logic                      core_start,
   output logic [2:0]                core_k,
   output logic [EK_BYTES_MAX*8-1:0] core_ek,
   output logic [MSG_BYTES*8-1:0]    core_mess,
   input  logic                      core_done,
   input  logic [CT_BYTES_MAX*8-1:0] core_c,
   input  logic [KEY_WIDTH-1:0]      core_K
);

   localparam int c_BUF_MAX = (EK_BYTES_MAX > CT_BYTES_MAX) ? EK_BYTES_MAX : CT_BYTES_MAX;
   localparam int IW        = $clog2(c_BUF_MAX + 1);
   localparam int MW        = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD_EK = 3'd1,
      S_LOAD_M  = 3'd2,
      S_RUN     = 3'd3,
      S_DRAIN   = 3'd4,
      S_ERR     = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [2:0]           k_q, k_d;
   logic [IW-1:0]        ek_len_q, ek_len_d;
   logic [IW-1:0]        chk_len_q, chk_len_d;
   logic [IW-1:0]        ct_len_q, ct_len_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [IW-1:0]        oidx_q, oidx_d;
   logic [1:0]           ph_q, ph_d;
   logic [7:0]           b0_q, b0_d;
   logic [7:0]           b1_q, b1_d;
   logic                 bad_q, bad_d;
   logic [KEY_WIDTH-1:0] key_q, key_d;
   logic                 done_q, done_d;
   logic                 error_q, error_d;
   logic                 core_start_q, core_start_d;
   logic                 in_ready_q, in_ready_d;
   logic                 out_valid_q, out_valid_d;

   logic                 w_in_xfer, w_out_xfer, w_mode_bad;
   logic                 w_ek_we, w_m_we, w_ct_we;

   logic [7:0]           ek_mem   [EK_BYTES_MAX];
   logic [7:0]           mess_mem [MSG_BYTES];
   logic [7:0]           ct_mem   [CT_BYTES_MAX];

   assign w_in_xfer  = in_valid & in_ready_q;
   assign w_out_xfer = out_valid_q & out_ready;
   // Rank 4 is only legal when the buffers were sized for it.
   assign w_mode_bad = (mode == 2'd3) || ((int'(mode) + 2) > K_MAX);

   // Next-state, counters, modulus check and output pulses.
   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      ek_len_d     = ek_len_q;
      chk_len_d    = chk_len_q;
      ct_len_d     = ct_len_q;
      idx_d        = idx_q;
      oidx_d       = oidx_q;
      ph_d         = ph_q;
      b0_d         = b0_q;
      b1_d         = b1_q;
      bad_d        = bad_q;
      key_d        = key_q;
      done_d       = 1'b0;
      error_d      = error_q;
      core_start_d = 1'b0;
      w_ek_we      = 1'b0;
      w_m_we       = 1'b0;
      w_ct_we      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (w_mode_bad) begin
                  done_d  = 1'b1;
                  error_d = 1'b1;
               end else begin
                  case (mode)
                     2'd0: begin
                        k_d = 3'd2; ek_len_d = IW'(800);  chk_len_d = IW'(768);  ct_len_d = IW'(768);
                     end
                     2'd1: begin
                        k_d = 3'd3; ek_len_d = IW'(1184); chk_len_d = IW'(1152); ct_len_d = IW'(1088);
                     end
                     default: begin
                        k_d = 3'd4; ek_len_d = IW'(1568); chk_len_d = IW'(1536); ct_len_d = IW'(1568);
                     end
                  endcase
                  key_d   = '0;
                  error_d = 1'b0;
                  idx_d   = '0;
                  oidx_d  = '0;
                  ph_d    = 2'd0;
                  bad_d   = 1'b0;
                  state_d = S_LOAD_EK;
               end
            end
         end
         S_LOAD_EK: begin
            if (w_in_xfer) begin
               w_ek_we = 1'b1;
               // Only the polynomial part is range-checked; rho passes through.
               if (idx_q < chk_len_q) begin
                  case (ph_q)
                     2'd0: begin
                        b0_d = in_data;
                        ph_d = 2'd1;
                     end
                     2'd1: begin
                        b1_d = in_data;
                        ph_d = 2'd2;
                     end
                     default: begin
                        ph_d = 2'd0;
                        if (({b1_q[3:0], b0_q} >= 12'd3329) || ({in_data, b1_q[7:4]} >= 12'd3329)) begin
                           bad_d = 1'b1;
                        end
                     end
                  endcase
               end
               if (idx_q == ek_len_q - IW'(1)) begin
                  idx_d   = '0;
                  state_d = S_LOAD_M;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         S_LOAD_M: begin
            if (w_in_xfer) begin
               w_m_we = 1'b1;
               if (idx_q == IW'(MSG_BYTES - 1)) begin
                  idx_d = '0;
                  if (bad_q) begin
                     state_d = S_ERR;
                     done_d  = 1'b1;
                     error_d = 1'b1;
                  end else begin
                     state_d      = S_RUN;
                     core_start_d = 1'b1;
                  end
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         S_RUN: begin
            if (core_done) begin
               w_ct_we = 1'b1;
               key_d   = core_K;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_out_xfer) begin
               if (oidx_q == ct_len_q - IW'(1)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  error_d = 1'b0;
               end else begin
                  oidx_d = oidx_q + IW'(1);
               end
            end
         end
         S_ERR: begin
            key_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      in_ready_d  = (state_d == S_LOAD_EK) || (state_d == S_LOAD_M);
      out_valid_d = (state_d == S_DRAIN);
   end

   // Control state register; reset aborts any operation without a done pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         k_q          <= '0;
         ek_len_q     <= '0;
         chk_len_q    <= '0;
         ct_len_q     <= '0;
         idx_q        <= '0;
         oidx_q       <= '0;
         ph_q         <= '0;
         b0_q         <= '0;
         b1_q         <= '0;
         bad_q        <= 1'b0;
         key_q        <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         core_start_q <= 1'b0;
         in_ready_q   <= 1'b0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         ek_len_q     <= ek_len_d;
         chk_len_q    <= chk_len_d;
         ct_len_q     <= ct_len_d;
         idx_q        <= idx_d;
         oidx_q       <= oidx_d;
         ph_q         <= ph_d;
         b0_q         <= b0_d;
         b1_q         <= b1_d;
         bad_q        <= bad_d;
         key_q        <= key_d;
         done_q       <= done_d;
         error_q      <= error_d;
         core_start_q <= core_start_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
      end
   end

   // Data buffers carry no reset; their contents are only read once written.
   always_ff @(posedge clk) begin
      if (w_ek_we) begin
         ek_mem[idx_q] <= in_data;
      end
      if (w_m_we) begin
         mess_mem[idx_q[MW-1:0]] <= in_data;
      end
      if (w_ct_we) begin
         for (int i = 0; i < CT_BYTES_MAX; i++) begin
            ct_mem[i] <= core_c[8*i +: 8];
         end
      end
   end

   generate
      for (genvar gi = 0; gi < EK_BYTES_MAX; gi++) begin : g_ek_pack
         assign core_ek[8*gi +: 8] = ek_mem[gi];
      end
      for (genvar gm = 0; gm < MSG_BYTES; gm++) begin : g_mess_pack
         assign core_mess[8*gm +: 8] = mess_mem[gm];
      end
   endgenerate

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_valid_q ? ct_mem[oidx_q] : 8'h00;
   assign out_last   = out_valid_q && (oidx_q == ct_len_q - IW'(1));
   assign K          = key_q;
   assign done       = done_q;
   assign error      = error_q;
   assign busy       = (state_q != S_IDLE);
   assign core_start = core_start_q;
   assign core_k     = k_q;

endmodule
`default_nettype wire

// File: tb/tb_ml_kem_encaps_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_ml_kem_encaps_stream
// Description : Self-checking bench for ml_kem_encaps_stream with a
//               behavioural encaps-core model and a stream-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ml_kem_encaps_stream;

   localparam int EKM  = 1568;
   localparam int CTM  = 1568;
   localparam int MSGB = 32;
   localparam int KW   = 256;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [1:0]      mode = 2'd0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [7:0]      in_data = 8'h00;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [7:0]      out_data;
   logic            out_last;
   logic [KW-1:0]   K;
   logic            done;
   logic            error;
   logic            busy;
   logic            core_start;
   logic [2:0]      core_k;
   logic [EKM*8-1:0] core_ek;
   logic [MSGB*8-1:0] core_mess;
   logic            core_done = 1'b0;
   logic [CTM*8-1:0] core_c = '0;
   logic [KW-1:0]   core_K = '0;

   int checks = 0;
   int errors = 0;

   // Reference data for the current operation
   logic [7:0]    ek_b   [EKM];
   logic [7:0]    m_b    [MSGB];
   logic [7:0]    ct_ret [CTM];
   logic [KW-1:0] key_ret;

   // Observations from the last operation
   int            n_in, n_cs, ek_mis, n_last, last_pos, stall_bad, overlap, busy_bad;
   logic [2:0]    cs_k;
   bit            ov_seen, done_seen, err_at_done, done_after, err_after;
   logic [KW-1:0] key_at_done;
   logic [7:0]    out_q [$];

   ml_kem_encaps_stream dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mode       (mode),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .K          (K),
      .done       (done),
      .error      (error),
      .busy       (busy),
      .core_start (core_start),
      .core_k     (core_k),
      .core_ek    (core_ek),
      .core_mess  (core_mess),
      .core_done  (core_done),
      .core_c     (core_c),
      .core_K     (core_K)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int ct_len_of(input int k);
      case (k)
         2:       return 768;
         3:       return 1088;
         default: return 1568;
      endcase
   endfunction

   // Unpack every 12-bit coefficient of ek and test it against q = 3329.
   function automatic bit model_bad(input int k);
      int b0, b1, b2;
      for (int t = 0; t < 128*k; t++) begin
         b0 = int'(ek_b[3*t]);
         b1 = int'(ek_b[3*t+1]);
         b2 = int'(ek_b[3*t+2]);
         if ((b0 + 256*(b1 % 16)) >= 3329) return 1'b1;
         if ((b1 / 16 + 16*b2) >= 3329) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic int out_mism(input int n);
      int e;
      e = 0;
      for (int i = 0; i < n; i++) if (out_q[i] !== ct_ret[i]) e++;
      return e;
   endfunction

   // kind 0: all legal, 1: uniform 12-bit, 2: legal with one out-of-range coefficient
   task automatic fill_ek(input int k, input int kind);
      int c0, c1, badpos;
      badpos = $urandom_range(256*k-1, 0);
      for (int t = 0; t < 128*k; t++) begin
         c0 = (kind == 1) ? $urandom_range(4095, 0) : $urandom_range(3328, 0);
         c1 = (kind == 1) ? $urandom_range(4095, 0) : $urandom_range(3328, 0);
         if (kind == 2 && badpos == 2*t)   c0 = $urandom_range(4095, 3329);
         if (kind == 2 && badpos == 2*t+1) c1 = $urandom_range(4095, 3329);
         ek_b[3*t]   = 8'(c0 % 256);
         ek_b[3*t+1] = 8'((c0 / 256) + 16*(c1 % 16));
         ek_b[3*t+2] = 8'(c1 / 16);
      end
      for (int i = 384*k; i < 384*k+32; i++) ek_b[i] = 8'($urandom);
      for (int i = 0; i < MSGB; i++) m_b[i] = 8'($urandom);
      for (int i = 0; i < CTM; i++) ct_ret[i] = 8'($urandom);
      for (int w = 0; w < KW/32; w++) key_ret[32*w +: 32] = $urandom;
   endtask

   task automatic drive_core_c(input bit inv);
      for (int i = 0; i < CTM; i++) core_c[8*i +: 8] = inv ? ~ct_ret[i] : ct_ret[i];
   endtask

   // Runs one operation: streams ek/m, models the core, collects ciphertext.
   // rdy_pat 0: always ready, 1: 1,0,0 repeating, 2: random.  abort_at >= 0
   // returns while byte abort_at is being presented.
   task automatic do_op(input int k, input int rdy_pat, input int vld_pat, input int lat, input int abort_at);
      int ekl, tot, in_pos, lat_cnt, ocyc;
      bit pend, prev_st, prev_last;
      logic [7:0] prev_d;
      ekl = 384*k + 32;
      tot = ekl + MSGB;
      n_in = 0; n_cs = 0; cs_k = 3'd0; ek_mis = 0; n_last = 0; last_pos = -1;
      stall_bad = 0; overlap = 0; busy_bad = 0; ov_seen = 0; done_seen = 0;
      err_at_done = 0; key_at_done = '0; out_q.delete();
      in_pos = 0; lat_cnt = 0; ocyc = 0; pend = 0; prev_st = 0; prev_last = 0; prev_d = 8'h00;
      @(negedge clk);
      start = 1'b1;
      mode  = 2'(k - 2);
      for (int cyc = 0; cyc < 30000; cyc++) begin
         @(negedge clk);
         start     = 1'b0;
         mode      = 2'($urandom);
         core_done = 1'b0;
         if (done) begin
            done_seen   = 1'b1;
            err_at_done = error;
            key_at_done = K;
            break;
         end
         if (!busy) busy_bad++;
         if (in_ready && out_valid) overlap++;
         if (core_start) begin
            n_cs++;
            cs_k    = core_k;
            pend    = 1'b1;
            lat_cnt = lat;
            for (int i = 0; i < ekl; i++) if (core_ek[8*i +: 8] !== ek_b[i]) ek_mis++;
            for (int i = 0; i < MSGB; i++) if (core_mess[8*i +: 8] !== m_b[i]) ek_mis++;
         end
         if (prev_st && (!out_valid || out_data !== prev_d || out_last !== prev_last)) stall_bad++;
         prev_st = 1'b0;
         if (out_valid) begin
            ov_seen = 1'b1;
            if (abort_at >= 0 && out_q.size() == abort_at) begin
               out_ready = 1'b0;
               in_valid  = 1'b0;
               return;
            end
            case (rdy_pat)
               0:       out_ready = 1'b1;
               1:       out_ready = (ocyc % 3 == 0);
               default: out_ready = ($urandom % 4) != 0;
            endcase
            ocyc++;
            if (out_ready) begin
               if (out_last) begin
                  n_last++;
                  last_pos = out_q.size();
               end
               out_q.push_back(out_data);
            end else begin
               prev_st   = 1'b1;
               prev_d    = out_data;
               prev_last = out_last;
            end
         end else begin
            out_ready = 1'($urandom);
         end
         if (in_pos < tot) begin
            in_valid = (vld_pat == 0) ? 1'b1 : (($urandom % 4) != 0);
            in_data  = (in_pos < ekl) ? ek_b[in_pos] : m_b[in_pos - ekl];
            if (in_valid && in_ready) begin
               in_pos++;
               n_in++;
            end
         end else begin
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            if (in_valid && in_ready) n_in++;
         end
         if (pend) begin
            if (lat_cnt == 0) begin
               drive_core_c(1'b0);
               core_K    = key_ret;
               core_done = 1'b1;
               pend      = 1'b0;
            end else begin
               lat_cnt--;
            end
         end else if ((in_ready || out_valid) && ($urandom % 40) == 0) begin
            drive_core_c(1'b1);
            core_K    = ~key_ret;
            core_done = 1'b1;
         end
      end
      start = 1'b0; in_valid = 1'b0; core_done = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      done_after = done;
      err_after  = error;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if ({done, error, busy, in_ready, out_valid, out_last, core_start} !== 7'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000000", {done, error, busy, in_ready, out_valid, out_last, core_start}); end
      checks++; if (K !== '0) begin errors++; $display("FAIL reset_K: got %h expected 0", K); end
      checks++; if ({core_k, out_data} !== 11'd0) begin errors++; $display("FAIL reset_k_data: got %h expected 0", {core_k, out_data}); end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if ({busy, in_ready, done} !== 3'b000) begin errors++; $display("FAIL idle_after_reset: got %b expected 000", {busy, in_ready, done}); end
   endtask

   task automatic test_happy_k3();
      for (int i = 0; i < 1152; i++) ek_b[i] = 8'h00;
      for (int i = 1152; i < 1184; i++) ek_b[i] = 8'hAA;
      for (int i = 0; i < MSGB; i++) m_b[i] = 8'h55;
      for (int i = 0; i < CTM; i++) ct_ret[i] = 8'(i % 256);
      key_ret = {32{8'h11}};
      do_op(3, 0, 0, 5, -1);
      checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL happy_done: got %0d expected 1", done_seen); end
      checks++; if (n_cs !== 1) begin errors++; $display("FAIL happy_core_start: got %0d expected 1", n_cs); end
      checks++; if (cs_k !== 3'd3) begin errors++; $display("FAIL happy_core_k: got %0d expected 3", cs_k); end
      checks++; if (ek_mis !== 0) begin errors++; $display("FAIL happy_core_buffers: got %0d bad bytes expected 0", ek_mis); end
      checks++; if (out_q.size() !== 1088) begin errors++; $display("FAIL happy_out_count: got %0d expected 1088", out_q.size()); end
      checks++; if (out_mism(1088) !== 0) begin errors++; $display("FAIL happy_out_bytes: got %0d wrong expected 0", out_mism(1088)); end
      checks++; if (n_last !== 1 || last_pos !== 1087) begin errors++; $display("FAIL happy_out_last: got n=%0d pos=%0d expected n=1 pos=1087", n_last, last_pos); end
      checks++; if (err_at_done !== 1'b0 || key_at_done !== {32{8'h11}}) begin errors++; $display("FAIL happy_result: got err=%0d K=%h expected err=0 K=11..11", err_at_done, key_at_done); end
      checks++; if (done_after !== 1'b0 || K !== {32{8'h11}}) begin errors++; $display("FAIL happy_after: got done=%0d K=%h expected done=0 K=11..11", done_after, K); end
      checks++; if (busy_bad !== 0 || overlap !== 0) begin errors++; $display("FAIL happy_busy_overlap: got %0d/%0d expected 0/0", busy_bad, overlap); end
   endtask

   task automatic test_modulus_violation();
      for (int i = 0; i < 800; i++) ek_b[i] = 8'h00;
      ek_b[3] = 8'h01; ek_b[4] = 8'hFD; ek_b[5] = 8'hFF;
      for (int i = 0; i < MSGB; i++) m_b[i] = 8'($urandom);
      do_op(2, 0, 1, 0, -1);
      checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL modviol_done: got %0d expected 1", done_seen); end
      checks++; if (n_in !== 832) begin errors++; $display("FAIL modviol_consumed: got %0d expected 832", n_in); end
      checks++; if (n_cs !== 0) begin errors++; $display("FAIL modviol_core_start: got %0d expected 0", n_cs); end
      checks++; if (err_at_done !== 1'b1 || key_at_done !== '0) begin errors++; $display("FAIL modviol_result: got err=%0d K=%h expected err=1 K=0", err_at_done, key_at_done); end
      checks++; if (ov_seen !== 1'b0) begin errors++; $display("FAIL modviol_out_valid: got %0d expected 0", ov_seen); end
      checks++; if (done_after !== 1'b0 || err_after !== 1'b1) begin errors++; $display("FAIL modviol_hold: got done=%0d err=%0d expected 0/1", done_after, err_after); end
   endtask

   task automatic test_boundary_legal();
      fill_ek(2, 0);
      ek_b[765] = 8'h00; ek_b[766] = 8'h0D; ek_b[767] = 8'hD0;
      for (int i = 768; i < 800; i++) ek_b[i] = 8'hFF;
      do_op(2, 2, 1, 1, -1);
      checks++; if (done_seen !== 1'b1 || err_at_done !== 1'b0) begin errors++; $display("FAIL boundary_result: got done=%0d err=%0d expected 1/0", done_seen, err_at_done); end
      checks++; if (n_cs !== 1 || cs_k !== 3'd2) begin errors++; $display("FAIL boundary_core: got starts=%0d k=%0d expected 1/2", n_cs, cs_k); end
      checks++; if (out_q.size() !== 768 || out_mism(768) !== 0) begin errors++; $display("FAIL boundary_out: got n=%0d wrong=%0d expected 768/0", out_q.size(), out_mism(out_q.size() < 768 ? out_q.size() : 768)); end
   endtask

   task automatic test_backpressure_k4();
      fill_ek(4, 0);
      do_op(4, 1, 1, 7, -1);
      checks++; if (out_q.size() !== 1568) begin errors++; $display("FAIL bp_out_count: got %0d expected 1568", out_q.size()); end
      checks++; if (out_mism(out_q.size() < 1568 ? out_q.size() : 1568) !== 0) begin errors++; $display("FAIL bp_out_bytes: got %0d wrong expected 0", out_mism(out_q.size() < 1568 ? out_q.size() : 1568)); end
      checks++; if (stall_bad !== 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes expected 0", stall_bad); end
      checks++; if (n_last !== 1 || last_pos !== 1567) begin errors++; $display("FAIL bp_out_last: got n=%0d pos=%0d expected 1/1567", n_last, last_pos); end
      checks++; if (err_at_done !== 1'b0 || key_at_done !== key_ret || cs_k !== 3'd4) begin errors++; $display("FAIL bp_result: got err=%0d k=%0d K=%h expected 0/4/%h", err_at_done, cs_k, key_at_done, key_ret); end
   endtask

   task automatic test_illegal_mode();
      int busy_hits;
      busy_hits = 0;
      @(negedge clk);
      start = 1'b1;
      mode  = 2'd3;
      @(negedge clk);
      start = 1'b0;
      mode  = 2'd0;
      if (busy) busy_hits++;
      checks++; if (done !== 1'b1 || error !== 1'b1) begin errors++; $display("FAIL illegal_done: got done=%0d err=%0d expected 1/1", done, error); end
      @(negedge clk);
      if (busy) busy_hits++;
      checks++; if (done !== 1'b0 || error !== 1'b1) begin errors++; $display("FAIL illegal_pulse: got done=%0d err=%0d expected 0/1", done, error); end
      checks++; if (busy_hits !== 0 || in_ready !== 1'b0) begin errors++; $display("FAIL illegal_busy: got busy=%0d in_ready=%0d expected 0/0", busy_hits, in_ready); end
   endtask

   task automatic test_reset_mid_op();
      int junk;
      fill_ek(3, 0);
      do_op(3, 2, 1, 4, 500);
      checks++; if (out_q.size() !== 500) begin errors++; $display("FAIL rst_reach_500: got %0d expected 500", out_q.size()); end
      rst = 1'b0;
      #1;
      checks++; if ({done, error, busy, in_ready, out_valid, out_last, core_start} !== 7'b0) begin errors++; $display("FAIL rst_mid_flags: got %b expected 0000000", {done, error, busy, in_ready, out_valid, out_last, core_start}); end
      checks++; if (K !== '0 || {core_k, out_data} !== 11'd0) begin errors++; $display("FAIL rst_mid_data: got K=%h k_data=%h expected 0", K, {core_k, out_data}); end
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      drive_core_c(1'b0);
      core_K    = key_ret;
      core_done = 1'b1;
      junk = 0;
      repeat (8) begin
         @(negedge clk);
         core_done = 1'b0;
         if (done || out_valid || busy || K !== '0) junk++;
      end
      checks++; if (junk !== 0) begin errors++; $display("FAIL rst_late_core_done: got %0d active cycles expected 0", junk); end
      fill_ek(3, 0);
      do_op(3, 0, 0, 2, -1);
      checks++; if (done_seen !== 1'b1 || err_at_done !== 1'b0 || key_at_done !== key_ret) begin errors++; $display("FAIL rst_next_op: got done=%0d err=%0d expected 1/0", done_seen, err_at_done); end
      checks++; if (out_q.size() !== 1088 || out_mism(out_q.size() < 1088 ? out_q.size() : 1088) !== 0) begin errors++; $display("FAIL rst_next_out: got n=%0d expected 1088 correct bytes", out_q.size()); end
   endtask

   task automatic test_random();
      int k, kind, ctl, nchk;
      bit exp_bad;
      for (int r = 0; r < 6; r++) begin
         k    = $urandom_range(4, 2);
         kind = $urandom_range(2, 0);
         fill_ek(k, kind);
         exp_bad = model_bad(k);
         ctl  = exp_bad ? 0 : ct_len_of(k);
         do_op(k, 2, 1, $urandom_range(6, 0), -1);
         nchk = (out_q.size() < ctl) ? out_q.size() : ctl;
         checks++; if (done_seen !== 1'b1 || err_at_done !== exp_bad) begin errors++; $display("FAIL rand%0d_error: got done=%0d err=%0d expected 1/%0d", r, done_seen, err_at_done, exp_bad); end
         checks++; if (n_in !== 384*k + 32 + MSGB) begin errors++; $display("FAIL rand%0d_consumed: got %0d expected %0d", r, n_in, 384*k + 32 + MSGB); end
         checks++; if (n_cs !== (exp_bad ? 0 : 1) || ek_mis !== 0) begin errors++; $display("FAIL rand%0d_core: got starts=%0d badbuf=%0d expected %0d/0", r, n_cs, ek_mis, exp_bad ? 0 : 1); end
         checks++; if (out_q.size() !== ctl || out_mism(nchk) !== 0) begin errors++; $display("FAIL rand%0d_out: got n=%0d wrong=%0d expected %0d/0", r, out_q.size(), out_mism(nchk), ctl); end
         checks++; if (key_at_done !== (exp_bad ? '0 : key_ret)) begin errors++; $display("FAIL rand%0d_K: got %h", r, key_at_done); end
         checks++; if (stall_bad !== 0 || overlap !== 0 || busy_bad !== 0) begin errors++; $display("FAIL rand%0d_handshake: got stall=%0d overlap=%0d busy=%0d expected 0", r, stall_bad, overlap, busy_bad); end
      end
   endtask

   initial begin
      test_reset();
      test_happy_k3();
      test_modulus_violation();
      test_boundary_legal();
      test_backpressure_k4();
      test_illegal_mode();
      test_reset_mid_op();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
